edge_detect_bank: RTL and testbench

EDGE_DETECT_BANK -- requirements
Module: edge_detect_bank

---
 rtl/edge_detect_bank.sv | 46 ++++
 tb/tb_edge_detect_bank.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/edge_detect_bank.sv
// edge_detect_bank: per-channel synchroniser, debouncer, edge pulse and sticky pending flags with irq
module edge_detect_bank #(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   signal_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [DEB_W-1:0]      deb_cycles,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_W-1:0]       cnt;
    logic                   lvl;
    logic                   lvl_d;
    logic                   pend;
    logic                   s;
    assign s = sync_q[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
        cnt    <= '0;
        lvl    <= 1'b0;
        lvl_d  <= 1'b0;
        pend   <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in[i]};
        cnt    <= (s == lvl || cnt == deb_cycles) ? '0 : cnt + DEB_W'(1);
        lvl    <= (s != lvl && cnt == deb_cycles) ? s : lvl;
        lvl_d  <= lvl;
        pend   <= pulse[i] | (pend & ~clear[i]);
      end
    end
    assign level[i]   = lvl;
    assign pending[i] = pend;
    assign pulse[i]   = (mode[2*i] & lvl & ~lvl_d) | (mode[2*i+1] & ~lvl & lvl_d);
  end
  assign irq = |pending;
endmodule

// File: tb/tb_edge_detect_bank.sv
// tb_edge_detect_bank: directed self-checking bench for edge_detect_bank
module tb_edge_detect_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  signal_in;
  logic [15:0] mode;
  logic [7:0]  deb_cycles;
  logic [7:0]  clear;
  logic [7:0]  level;
  logic [7:0]  pulse;
  logic [7:0]  pending;
  logic        irq;
  int          n_chk = 0;
  int          n_pass = 0;

  edge_detect_bank #(.CHANNELS(8), .SYNC_STAGES(2), .DEB_W(8)) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode),
    .deb_cycles(deb_cycles), .clear(clear), .level(level),
    .pulse(pulse), .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    rst = 1'b1; signal_in = '0; mode = '0; deb_cycles = '0; clear = '0;
    tick(2);
    check("rst_level", 32'(level), 32'h0);
    check("rst_pulse", 32'(pulse), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    tick(1);
    mode = 16'h0001;
    signal_in[0] = 1'b1;
    tick(1);
    check("lat_pulse_k", 32'(pulse), 32'h0);
    tick(1);
    check("lat_pulse_k1", 32'(pulse), 32'h0);
    check("lat_level_k1", 32'(level), 32'h0);
    tick(1);
    check("lat_pulse_k2", 32'(pulse), 32'h01);
    check("lat_level_k2", 32'(level), 32'h01);
    check("lat_pend_k2", 32'(pending), 32'h0);
    tick(1);
    check("lat_pulse_k3", 32'(pulse), 32'h0);
    check("lat_pend_k3", 32'(pending), 32'h01);
    check("lat_irq_k3", 32'(irq), 32'h1);
    clear = 8'h01;
    tick(1);
    clear = 8'h00;
    check("clr_pend", 32'(pending), 32'h0);
    check("clr_irq", 32'(irq), 32'h0);
    deb_cycles = 8'd4;
    mode = 16'h0004;
    signal_in[1] = 1'b1;
    tick(4);
    signal_in[1] = 1'b0;
    tick(10);
    check("glitch_level", 32'(level), 32'h01);
    check("glitch_pend", 32'(pending), 32'h0);
    signal_in[1] = 1'b1;
    tick(6);
    check("deb_level_early", 32'(level), 32'h01);
    check("deb_pulse_early", 32'(pulse), 32'h0);
    tick(1);
    check("deb_level", 32'(level), 32'h03);
    check("deb_pulse", 32'(pulse), 32'h02);
    tick(1);
    check("deb_pend", 32'(pending), 32'h02);
    clear = 8'hFF;
    tick(1);
    clear = 8'h00;
    deb_cycles = 8'd0;
    mode = 16'h0030;
    signal_in[2] = 1'b1;
    tick(2);
    check("both_rise_pre", 32'(pulse), 32'h0);
    tick(1);
    check("both_rise", 32'(pulse), 32'h04);
    tick(20);
    signal_in[2] = 1'b0;
    tick(3);
    check("both_fall", 32'(pulse), 32'h04);
    check("both_fall_level", 32'(level), 32'h03);
    mode = 16'h0020;
    signal_in[2] = 1'b1;
    tick(3);
    check("fall_only_rise", 32'(pulse), 32'h0);
    check("fall_only_level", 32'(level), 32'h07);
    tick(20);
    signal_in[2] = 1'b0;
    tick(3);
    check("fall_only_fall", 32'(pulse), 32'h04);
    tick(1);
    clear = 8'hFF;
    tick(1);
    clear = 8'h00;
    check("pre_t4_pend", 32'(pending), 32'h0);
    mode = 16'h0040;
    signal_in[3] = 1'b1;
    tick(3);
    check("setclr_pulse", 32'(pulse), 32'h08);
    clear = 8'h08;
    tick(1);
    check("setclr_pend", 32'(pending), 32'h08);
    tick(1);
    clear = 8'h00;
    check("clr_only_pend", 32'(pending), 32'h0);
    check("clr_only_irq", 32'(irq), 32'h0);
    mode = 16'hFFFF;
    signal_in = ~signal_in;
    tick(3);
    check("all_toggle_pulse", 32'(pulse), 32'hFF);
    tick(1);
    check("all_toggle_pend", 32'(pending), 32'hFF);
    deb_cycles = 8'd8;
    signal_in[0] = 1'b1;
    tick(5);
    check("mid_deb_level", 32'(level), 32'hF4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_level", 32'(level), 32'h0);
    check("mid_rst_pulse", 32'(pulse), 32'h0);
    check("mid_rst_pend", 32'(pending), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    tick(10);
    check("post_rst_early", 32'(level), 32'h0);
    tick(1);
    check("post_rst_level", 32'(level), 32'hF5);
    check("post_rst_pulse", 32'(pulse), 32'hF5);
    mode = 16'h0000;
    deb_cycles = 8'd0;
    signal_in = 8'h00;
    tick(5);
    clear = 8'hFF;
    tick(1);
    clear = 8'h00;
    check("pre_all_pend", 32'(pending), 32'h0);
    mode = 16'h5555;
    signal_in = 8'hFF;
    tick(2);
    check("all_rise_pre", 32'(pulse), 32'h0);
    tick(1);
    check("all_rise_pulse", 32'(pulse), 32'hFF);
    tick(1);
    check("all_rise_pend", 32'(pending), 32'hFF);
    check("all_rise_irq", 32'(irq), 32'h1);
    check("all_rise_after", 32'(pulse), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
